mac_feeder: RTL and testbench
=============================

# mac_feeder

Hardware sequencer that drives one `mac_array` instance through a full dot product. It accepts packed activation/weight vectors over a valid/ready stream and buffers them in a small FIFO. It issues one vector at a time to the array's `x`/`w` inputs, feeds the captured `psum_out` back as the next `psum_in`, and after `len` vectors presents the final partial sum on a valid/ready output. It sits between the activation/weight SRAM readers and the `mac_array`, on the driving side of the array's interface.

## Interface
- `bw`, 4: bits per activation/weight lane.
- `psum_bw`, 16: partial-sum width.
- `len`, 10: vectors per dot product; legal range ≥ 1.
- `mac_lat`, 1: `mac_array` latency in cycles, measured from the edge that changes `x`/`w`/`psum_in` to the edge at which `psum_out` is stable.
- `fifo_depth`, 4: input FIFO entries; must be a power of 2.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  FIFO can accept.
- `in_x`  in  4*bw  unsigned activations; lane u at [bw*u+bw-1 : bw*u].
- `in_w`  in  4*bw  signed (two's complement) weights; same lane packing as `in_x`.
- `x`  out  4*bw  to `mac_array.x`.
- `w`  out  4*bw  to `mac_array.w`.
- `psum_in`  out  psum_bw  to `mac_array.psum_in`.
- `psum_out`  in  psum_bw  from `mac_array.psum_out`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed.
- `out_psum`  out  psum_bw  final dot-product result.
- `busy`  out  1  high whenever the state is not FETCH or the vector count is non-zero.

## Operation
- FIFO: width 8*bw, depth `fifo_depth`.
  - Push occurs on `in_valid && in_ready`.
  - `in_ready = !full`, combinational from occupancy.
  - When full, a push is not accepted even if a pop occurs in the same cycle.
  - When not full, a simultaneous push and pop leaves occupancy unchanged.
  - Pointers wrap modulo `fifo_depth`.
- Registers: `acc` (psum_bw), `cnt` (vectors done, 0..len-1), `wcnt` (wait counter).
- States: FETCH, ISSUE, WAIT, DONE.
  - FETCH: if FIFO not empty, go to ISSUE.
  - ISSUE (1 cycle): pop the FIFO head. At the edge, `x`/`w` take the popped data and `psum_in` takes `acc`. Load `wcnt = mac_lat`. Go to WAIT.
  - WAIT: decrement `wcnt` each cycle.
    - In the cycle where `wcnt == 0`, capture `acc <= psum_out` at the edge.
    - If `cnt == len-1`, go to DONE.
    - Otherwise increment `cnt` and go to ISSUE if the FIFO is non-empty (checked in that cycle), else to FETCH.
  - DONE: `out_valid = 1`, `out_psum` = `acc`, post-processed per Configuration. On `out_ready`: clear `acc` and `cnt`, go to FETCH.
- The FIFO keeps accepting pushes in every state.
- `x`, `w` and `psum_in` hold their last issued values between issues; they are never driven to X.
- The block performs no arithmetic on the sum. `mac_array` does the multiply-accumulate, and `psum_bw` wrap-around is inherited unchanged (no saturation).
- Reset (asynchronous, any state, including mid-WAIT):
  - state ← FETCH; FIFO is emptied.
  - `acc`, `cnt`, `wcnt` ← 0.
  - `x`, `w`, `psum_in` ← 0; `out_valid` ← 0.
  - A partial dot product in progress is discarded.

## Timing
- Reset values: `in_ready` 1, `out_valid` 0, `out_psum` 0, `x`/`w`/`psum_in` 0, `busy` 0.
- Vector period is `mac_lat`+2 cycles when the FIFO is non-empty (ISSUE + `mac_lat`+1 WAIT cycles).
- FIFO data visibility: a push at edge E makes the FIFO non-empty in the cycle after E. FETCH transitions to ISSUE at edge E+1, so `x`/`w` update at edge E+2.
- `out_valid` rises at the edge after the final capture and holds until the `out_ready` handshake.
- Earliest next ISSUE after a result handshake: 2 cycles later (DONE→FETCH→ISSUE).

## Configuration
- `MAC_FEEDER_RELU_EN` defined: `out_psum` = 0 when `acc` is negative (MSB set), else `acc`. Internal `acc` and the `psum_in` feedback are unaffected.
- Not defined: `out_psum` = `acc` raw.

## Test plan
- All lanes x=1, w=1, 10 vectors back-to-back, `out_ready`=1 → `out_psum`=40. `out_valid` high for exactly 1 cycle. Vector issues occur every 3 cycles (`mac_lat`=1).
- All lanes x=15, w=-8, 10 vectors:
  - without the macro → `out_psum`=16'hED40 (-4800);
  - with `MAC_FEEDER_RELU_EN` → 0.
- `len`=200, all lanes x=15, w=7 → `out_psum`=18464 (84000 mod 65536), checking wrap-around.
- Hold `out_ready`=0 for 20 cycles after DONE while pushing 6 vectors:
  - `out_valid` and `out_psum`=40 stay stable;
  - FIFO fills to 4 and `in_ready` drops;
  - after `out_ready`, the next dot product starts from `acc`=0.
- `in_valid` pulsed once every 7 cycles (x=2, w=-1 all lanes) → block idles in FETCH between vectors, `busy` stays 1, final `out_psum`=16'hFFB0 (-80).
- Assert `reset_n`=0 during WAIT of vector 5 → all outputs are at reset values immediately (asynchronously). A following all-ones dot product gives `out_psum`=40.

Source files
------------

// File: rtl/mac_feeder.sv
// Sequences one mac_array through a len-vector dot product from a small input FIFO; MAC_FEEDER_RELU_EN clamps negative results to zero.
// Latency: mac_lat+2 cycles per vector when the FIFO is non-empty; result valid the edge after the final capture.
// Backpressure: in_ready drops when the FIFO is full; out_valid holds, and no new vector is issued, until out_ready.
module mac_feeder #(
    parameter int bw         = 4,
    parameter int psum_bw    = 16,
    parameter int len        = 10,
    parameter int mac_lat    = 1,
    parameter int fifo_depth = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*bw-1:0]      in_x,
    input  logic [4*bw-1:0]      in_w,
    output logic [4*bw-1:0]      x,
    output logic [4*bw-1:0]      w,
    output logic [psum_bw-1:0]   psum_in,
    input  logic [psum_bw-1:0]   psum_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [psum_bw-1:0]   out_psum,
    output logic                 busy
);

    localparam int DW = 8 * bw;
    localparam int PW = $clog2(fifo_depth);
    localparam int CW = (len > 1) ? $clog2(len) : 1;
    localparam int WW = (mac_lat > 0) ? $clog2(mac_lat + 1) : 1;

    typedef enum logic [1:0] {FETCH, ISSUE, WAIT, DONE} state_t;

    state_t               state_q;
    logic [DW-1:0]        mem_q [fifo_depth];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [PW:0]          occ_q;
    logic [psum_bw-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [WW-1:0]        wcnt_q;
    logic [4*bw-1:0]      x_q;
    logic [4*bw-1:0]      w_q;
    logic [psum_bw-1:0]   psum_in_q;
    logic                 out_valid_q;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DW-1:0]        head;

    assign full     = (occ_q == (PW+1)'(fifo_depth));
    assign empty    = (occ_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // ISSUE is only entered with a non-empty FIFO, so the pop never underflows.
    assign pop      = (state_q == ISSUE);
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_x, in_w};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            occ_q <= occ_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            acc_q       <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            x_q         <= '0;
            w_q         <= '0;
            psum_in_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!empty) state_q <= ISSUE;
                end
                ISSUE: begin
                    x_q       <= head[DW-1:4*bw];
                    w_q       <= head[4*bw-1:0];
                    psum_in_q <= acc_q;
                    wcnt_q    <= WW'(mac_lat);
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (wcnt_q == '0) begin
                        acc_q <= psum_out;
                        if (cnt_q == CW'(len - 1)) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                            state_q <= empty ? FETCH : ISSUE;
                        end
                    end else begin
                        wcnt_q <= wcnt_q - WW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign x         = x_q;
    assign w         = w_q;
    assign psum_in   = psum_in_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != FETCH) || (cnt_q != '0);

`ifdef MAC_FEEDER_RELU_EN
    assign out_psum = acc_q[psum_bw-1] ? '0 : acc_q;
`else
    assign out_psum = acc_q;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Randomised and directed bench for mac_feeder, with a behavioural mac_array and a dot-product scoreboard.
module tb_mac_feeder;

    localparam int BW         = 4;
    localparam int PSUM_BW    = 16;
    localparam int LEN        = 10;
    localparam int LONG_LEN   = 200;
    localparam int MAC_LAT    = 1;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic               in_valid, in_ready, out_valid, out_ready, busy;
    logic [4*BW-1:0]    in_x, in_w, x, w;
    logic [PSUM_BW-1:0] psum_in, psum_out, out_psum;

    logic               l_in_valid, l_in_ready, l_out_valid, l_busy;
    logic [4*BW-1:0]    l_in_x, l_in_w, l_x, l_w;
    logic [PSUM_BW-1:0] l_psum_in, l_psum_out, l_out_psum;

    mac_feeder #(.bw(BW), .psum_bw(PSUM_BW), .len(LEN), .mac_lat(MAC_LAT), .fifo_depth(FIFO_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_w(in_w), .x(x), .w(w), .psum_in(psum_in), .psum_out(psum_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .busy(busy)
    );

    mac_feeder #(.bw(BW), .psum_bw(PSUM_BW), .len(LONG_LEN), .mac_lat(MAC_LAT), .fifo_depth(FIFO_DEPTH)) dut_long (
        .clk(clk), .reset_n(reset_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .in_x(l_in_x), .in_w(l_in_w), .x(l_x), .w(l_w), .psum_in(l_psum_in), .psum_out(l_psum_out),
        .out_valid(l_out_valid), .out_ready(1'b1), .out_psum(l_out_psum), .busy(l_busy)
    );

    // Unsigned activations times signed weights, summed over the four lanes.
    function automatic int dot(input logic [4*BW-1:0] xv, input logic [4*BW-1:0] wv);
        int s;
        s = 0;
        for (int u = 0; u < 4; u++) s += int'(xv[BW*u +: BW]) * int'($signed(wv[BW*u +: BW]));
        return s;
    endfunction

    function automatic logic [PSUM_BW-1:0] relu(input logic [PSUM_BW-1:0] v);
`ifdef MAC_FEEDER_RELU_EN
        return v[PSUM_BW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Behavioural mac_array: psum_out = psum_in + x.w, mac_lat edges later.
    logic [PSUM_BW-1:0] mac_pipe [MAC_LAT];
    logic [PSUM_BW-1:0] l_mac_pipe [MAC_LAT];
    always @(posedge clk) begin
        mac_pipe[0]   <= psum_in + PSUM_BW'(dot(x, w));
        l_mac_pipe[0] <= l_psum_in + PSUM_BW'(dot(l_x, l_w));
        for (int i = 1; i < MAC_LAT; i++) begin
            mac_pipe[i]   <= mac_pipe[i-1];
            l_mac_pipe[i] <= l_mac_pipe[i-1];
        end
    end
    assign psum_out   = mac_pipe[MAC_LAT-1];
    assign l_psum_out = l_mac_pipe[MAC_LAT-1];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted vector's dot product, consumed len at a time per result.
    int sbq[$];
    int sb_sum;
    int n_res = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                if (sbq.size() < LEN) begin
                    chk("sb_underflow", sbq.size(), LEN);
                end else begin
                    sb_sum = 0;
                    for (int i = 0; i < LEN; i++) sb_sum += sbq.pop_front();
                    chk("sb_result", out_psum, relu(PSUM_BW'(sb_sum)));
                end
                n_res++;
            end
            if (in_valid && in_ready) sbq.push_back(dot(in_x, in_w));
        end
    end

    task automatic push(input logic [4*BW-1:0] xv, input logic [4*BW-1:0] wv);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_x = xv;
        in_w = wv;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 500) begin
                chk("push_timeout", in_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [PSUM_BW-1:0] exp);
        int c;
        c = 0;
        while (!out_valid && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!out_valid) chk({tag, "_timeout"}, out_valid, 1);
        else chk(tag, out_psum, exp);
        if (out_valid && out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_psum"}, out_psum, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_w"}, w, 0);
        chk({tag, "_psum_in"}, psum_in, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    localparam logic [4*BW-1:0] ONES = 16'h1111;

    int lat;
    int acc_cnt;
    int base;
    bit rdone;

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b1;
        l_in_valid = 1'b0; l_in_x = '0; l_in_w = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // All ones, back-to-back: first push to out_valid is 1 + len*(mac_lat+2) edges.
        push(ONES, ONES);
        lat = -1;
        fork
            for (int i = 0; i < LEN - 1; i++) push(ONES, ONES);
            begin
                for (int c = 1; c <= 200; c++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) begin
                        lat = c;
                        break;
                    end
                end
                chk("ones_latency", lat, 1 + LEN * (MAC_LAT + 2));
                chk("ones_psum", out_psum, relu(16'd40));
                @(posedge clk);
                #1;
                chk("ones_valid_pulse", out_valid, 0);
            end
        join

        // Large negative sum; clamped when ReLU is built in.
        fork
            for (int i = 0; i < LEN; i++) push(16'hFFFF, 16'h8888);
            wait_result("neg_psum", relu(16'hED40));
        join

        // len=200 instance: 84000 wraps to 18464.
        acc_cnt = 0;
        l_in_x = 16'hFFFF;
        l_in_w = 16'h7777;
        l_in_valid = 1'b1;
        for (int c = 0; c < 2000 && acc_cnt < LONG_LEN; c++) begin
            @(negedge clk);
            if (l_in_ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        l_in_valid = 1'b0;
        chk("long_accepted", acc_cnt, LONG_LEN);
        for (int c = 0; c < 2000 && !l_out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        chk("long_valid", l_out_valid, 1);
        chk("long_psum", l_out_psum, relu(16'd18464));
        @(posedge clk);
        #1;

        // Result held under backpressure while the FIFO fills behind it.
        out_ready = 1'b0;
        fork
            for (int i = 0; i < LEN; i++) push(ONES, ONES);
            wait_result("hold_first", relu(16'd40));
        join
        fork
            for (int i = 0; i < 6; i++) push(ONES, ONES);
            begin
                for (int c = 0; c < 20; c++) begin
                    @(posedge clk);
                    #1;
                    chk("hold_valid", out_valid, 1);
                    chk("hold_psum", out_psum, relu(16'd40));
                end
                chk("hold_full_in_ready", in_ready, 0);
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                chk("hold_released", out_valid, 0);
            end
        join
        fork
            for (int i = 0; i < 4; i++) push(ONES, ONES);
            wait_result("after_hold_psum", relu(16'd40));
        join

        // Sparse input: the block idles in FETCH between vectors but stays busy.
        for (int i = 0; i < LEN; i++) begin
            push(16'h2222, 16'hFFFF);
            if (i < LEN - 1) begin
                repeat (5) @(posedge clk);
                #1;
                chk("sparse_busy", busy, 1);
                @(posedge clk);
                #1;
            end
        end
        wait_result("sparse_psum", relu(16'hFFB0));

        // Asynchronous reset in the WAIT phase of the fifth vector.
        push(16'h3333, 16'h3333);
        fork
            for (int i = 0; i < 5; i++) push(16'h3333, 16'h3333);
            begin
                repeat (14) @(posedge clk);
                #1;
                chk("pre_reset_x", x, 16'h3333);
                #2;
                reset_n = 1'b0;
                sbq.delete();
                #1;
                check_reset_values("async_reset");
            end
        join
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        fork
            for (int i = 0; i < LEN; i++) push(ONES, ONES);
            wait_result("post_reset_psum", relu(16'd40));
        join

        // Random vectors, random input gaps and random result backpressure.
        base = n_res;
        rdone = 1'b0;
        fork
            for (int i = 0; i < 3 * LEN; i++) begin
                push(16'($urandom), 16'($urandom));
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            while (!rdone) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
            begin
                for (int c = 0; c < 3000 && n_res < base + 3; c++) @(posedge clk);
                chk("rand_results", n_res - base, 3);
                rdone = 1'b1;
            end
        join
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
